// File: rtl/imem_boot_loader.sv
// imem_boot_loader
//   Streams a program image from a byte source into main memory through a
//   single write port, then releases the core from reset.
//   Image layout (all little-endian): 32-bit word count N, N data words,
//   32-bit XOR checksum of the data words.
//
// Ports
//   clock        : system clock, rising edge
//   reset        : asynchronous, active-low reset
//   start        : 1-cycle pulse, begins a load (ignored while busy)
//   in_valid     : byte source has in_data
//   in_data      : image byte
//   in_ready     : loader accepts a byte this cycle
//   mem_we       : 1-cycle word write strobe
//   mem_addr     : word address of the write
//   mem_wdata    : write data
//   core_reset   : active-high core hold, low only after a good load
//   busy         : load in progress (header, data or checksum)
//   done         : image loaded and checksum matched
//   error        : oversize word count or checksum mismatch
//   words_loaded : data words written in the current load
module imem_boot_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  core_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_LOAD,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  // Largest word count that fits above BASE_ADDR without wrapping.
  localparam logic [32:0] LIMIT = (33'd1 << ADDR_WIDTH) - 33'(BASE_ADDR);

  state_t                state;
  state_t                nxt;
  logic [1:0]            bcnt;
  logic [23:0]           asm_q;     // first three bytes of the current field
  logic [ADDR_WIDTH:0]   count_n;
  logic [31:0]           csum;

  logic                  xfer;
  logic                  last;
  logic                  oversize;
  logic                  idle_like;
  logic [31:0]           word;
  logic [ADDR_WIDTH:0]   wl_next;

  always_comb begin
    xfer      = in_valid & in_ready;
    last      = xfer & (bcnt == 2'd3);
    word      = {in_data, asm_q};
    oversize  = {1'b0, word} > LIMIT;
    wl_next   = words_loaded + 1'b1;
    idle_like = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR);
    nxt       = state;
    unique case (state)
      S_IDLE, S_DONE, S_ERR: if (start) nxt = S_HDR;
      S_HDR: begin
        if (last) begin
          if (oversize)        nxt = S_ERR;
          else if (word == '0) nxt = S_CSUM;
          else                 nxt = S_LOAD;
        end
      end
      S_LOAD: if (last && (wl_next == count_n)) nxt = S_CSUM;
      S_CSUM: if (last) nxt = (csum == word) ? S_DONE : S_ERR;
    endcase
  end

  // Status outputs are registered from the next state so they change in
  // the same cycle as the state they describe.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      in_ready     <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      core_reset   <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
      bcnt         <= '0;
      asm_q        <= '0;
      count_n      <= '0;
      csum         <= '0;
    end else begin
      state      <= nxt;
      in_ready   <= (nxt == S_HDR) || (nxt == S_LOAD) || (nxt == S_CSUM);
      busy       <= (nxt == S_HDR) || (nxt == S_LOAD) || (nxt == S_CSUM);
      done       <= (nxt == S_DONE);
      error      <= (nxt == S_ERR);
      core_reset <= (nxt != S_DONE);
      mem_we     <= 1'b0;
      if (start && idle_like) begin
        bcnt         <= '0;
        asm_q        <= '0;
        count_n      <= '0;
        csum         <= '0;
        words_loaded <= '0;
      end else if (xfer) begin
        bcnt  <= bcnt + 2'd1;
        asm_q <= {in_data, asm_q[23:8]};
        if (last) begin
          unique case (state)
            S_HDR: count_n <= word[ADDR_WIDTH:0];
            S_LOAD: begin
              mem_we       <= 1'b1;
              mem_addr     <= ADDR_WIDTH'(BASE_ADDR) + words_loaded[ADDR_WIDTH-1:0];
              mem_wdata    <= word;
              words_loaded <= wl_next;
              csum         <= csum ^ word;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader
//   Scoreboarded bench for imem_boot_loader. The driver pushes each expected
//   memory write into a queue as it issues the word's bytes; a monitor pops
//   and compares on every mem_we. Final status is predicted from the image
//   contents (size limit, XOR of the data words).
module tb_imem_boot_loader;

  localparam int AW   = 10;
  localparam int BASE = 0;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic            in_valid;
  logic [7:0]      in_data;
  logic            in_ready;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [31:0]     mem_wdata;
  logic            core_reset;
  logic            busy;
  logic            done;
  logic            error;
  logic [AW:0]     words_loaded;

  imem_boot_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .clock        (clk),
    .reset        (rst_n),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .core_reset   (core_reset),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [AW:0]   wl;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] img[0:1023];
  int          tests = 0;
  int          fails = 0;
  logic        prev_we = 1'b0;
  logic        stray_start = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write must match the next scoreboard entry, and a
  // strobe may never last two cycles.
  always @(negedge clk) begin
    if (mem_we) begin
      if (prev_we) begin
        tests++;
        fails++;
        $display("FAIL we_width: mem_we high for two consecutive cycles at addr %h", mem_addr);
      end
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: addr %h data %h, none expected", mem_addr, mem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        tests++;
        if ({mem_addr, mem_wdata, words_loaded} !== {e.addr, e.data, e.wl}) begin
          fails++;
          $display("FAIL write: got addr %h data %h wl %0d expected addr %h data %h wl %0d",
                   mem_addr, mem_wdata, words_loaded, e.addr, e.data, e.wl);
        end
      end
    end
    prev_we = mem_we;
  end

  task automatic send_byte(input logic [7:0] b, input int gapmax);
    int gap;
    int budget;
    gap = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
      start    = 1'b0;
    end
    @(negedge clk);
    in_valid    = 1'b1;
    in_data     = b;
    start       = stray_start;
    stray_start = 1'b0;
    budget      = 20;
    while (!in_ready && budget > 0) begin
      @(negedge clk);
      start = 1'b0;
      budget--;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL in_ready_timeout: got in_ready=0 expected 1 within 20 cycles");
      in_valid = 1'b0;
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int gapmax);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gapmax);
  endtask

  function automatic logic [31:0] image_xor(input int n);
    logic [31:0] x;
    x = '0;
    for (int i = 0; i < n; i++) x ^= img[i];
    return x;
  endfunction

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_status", {59'd0, busy, core_reset, done, error, in_ready},
          {59'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
    check("start_wl", 64'(words_loaded), 64'd0);
  endtask

  // Load one image (count n, data from img[], checksum c) and check the end state.
  task automatic run_image(input logic [31:0] n, input logic [31:0] c, input int gapmax,
                           input bit with_stray);
    bit over;
    bit good;
    over = (64'(n) > 64'((1 << AW) - BASE));
    good = !over && (image_xor(int'(n)) == c);
    pulse_start();
    send_word(n, gapmax);
    if (!over) begin
      for (int i = 0; i < int'(n); i++) begin
        wr_t e;
        e.addr = AW'(BASE + i);
        e.data = img[i];
        e.wl   = (AW+1)'(i + 1);
        exp_q.push_back(e);
        if (i == 0 && with_stray) stray_start = 1'b1;
        send_word(img[i], gapmax);
      end
      send_word(c, gapmax);
    end
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b0;
    #1;
    check("end_status", {59'd0, busy, core_reset, done, error, in_ready},
          {59'd0, 1'b0, !good, good, !good, 1'b0});
    check("end_wl", 64'(words_loaded), over ? 64'd0 : 64'(n));
    check("pending_writes", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic load_t1();
    img[0] = 32'h0000_0013;
    img[1] = 32'h0050_0093;
    img[2] = 32'h0010_8133;
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(negedge clk);
    check("reset_vals", 64'({in_ready, mem_we, mem_addr, mem_wdata, core_reset, busy, done, error, words_loaded}),
          64'({1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0}));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed images: good, bad checksum, empty, oversize, bubbles.
    load_t1();
    run_image(32'd3, 32'h0040_81B3, 0, 1'b0);
    run_image(32'd3, 32'h0040_81B2, 0, 1'b0);
    run_image(32'd0, 32'd0, 0, 1'b0);
    run_image(32'd1025, 32'd0, 0, 1'b0);
    run_image(32'd3, 32'h0040_81B3, 3, 1'b1);

    // Reset in the middle of the second data word.
    pulse_start();
    send_word(32'd3, 0);
    begin
      wr_t e;
      e.addr = AW'(BASE);
      e.data = img[0];
      e.wl   = 11'd1;
      exp_q.push_back(e);
    end
    send_word(img[0], 0);
    send_byte(img[1][7:0], 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("midload_reset_vals", 64'({in_ready, mem_we, mem_addr, mem_wdata, core_reset, busy, done, error, words_loaded}),
          64'({1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0}));
    check("midload_pending", 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run_image(32'd3, 32'h0040_81B3, 0, 1'b0);

    // Randomised images, some with corrupted checksums.
    for (int r = 0; r < 20; r++) begin
      int unsigned n;
      logic [31:0] c;
      n = $urandom_range(12, 0);
      for (int i = 0; i < int'(n); i++) img[i] = $urandom;
      c = image_xor(int'(n));
      if ($urandom_range(9, 0) < 3) c ^= (32'd1 << $urandom_range(31, 0));
      run_image(n, c, int'($urandom_range(3, 0)), ($urandom_range(1, 0) == 1));
    end

    // Size boundary: exactly full memory, then random oversize counts.
    for (int i = 0; i < 1024; i++) img[i] = $urandom;
    run_image(32'd1024, image_xor(1024), 0, 1'b0);
    run_image(32'd1025 + $urandom_range(1000, 0), 32'd0, 1, 1'b0);
    run_image(32'hFFFF_FFFF, 32'd0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
